display_pwm_blanker: RTL and testbench

//  Parametrised brightness and blink controller for the seven-segment display path.

---
 rtl/display_pwm_blanker.sv | 98 +++++++++
 tb/tb_display_pwm_blanker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/display_pwm_blanker.sv
// Brightness and blink controller for the seven-segment path: internal PWM with
// per-period duty latching, per-digit blink masking and registered Blank/DP flags.
module display_pwm_blanker #(
   parameter int NUM_DIGITS    = 6,
   parameter int PWM_WIDTH     = 8,
   parameter int BLINK_PERIODS = 48828
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [PWM_WIDTH-1:0]  duty,
   input  logic [NUM_DIGITS-1:0] blank_in,
   input  logic [NUM_DIGITS-1:0] dp_in,
   input  logic [NUM_DIGITS-1:0] blink_mask,
   output logic [NUM_DIGITS-1:0] Blank,
   output logic [NUM_DIGITS-1:0] DP,
   output logic                  pwm_out,
   output logic                  period_tick
);

   localparam int BLINK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
   localparam logic [PWM_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [BLINK_W-1:0]   BLINK_LAST = BLINK_W'(BLINK_PERIODS - 1);

   logic [PWM_WIDTH-1:0]  pwm_cnt_reg, pwm_cnt_next;
   logic [PWM_WIDTH-1:0]  duty_q_reg, duty_q_next;
   logic [BLINK_W-1:0]    blink_cnt_reg, blink_cnt_next;
   logic                  blink_phase_reg, blink_phase_next;
   logic                  enable_d_reg;
   logic                  en_rise, wrap, pwm_on;
   logic [PWM_WIDTH-1:0]  duty_eff;
   logic [NUM_DIGITS-1:0] blank_next, dp_next;

   // On the enable-rise cycle the freshly loaded duty already governs pwm_cnt=0,
   // so the first on-phase after a restart uses the new duty.
   always_comb begin
      en_rise          = enable & ~enable_d_reg;
      wrap             = enable & (pwm_cnt_reg == CNT_MAX);
      duty_eff         = en_rise ? duty : duty_q_reg;
      pwm_on           = (pwm_cnt_reg < duty_eff);
      pwm_cnt_next     = pwm_cnt_reg;
      duty_q_next      = duty_q_reg;
      blink_cnt_next   = blink_cnt_reg;
      blink_phase_next = blink_phase_reg;
      if (!enable) begin
         pwm_cnt_next     = '0;
         blink_cnt_next   = '0;
         blink_phase_next = 1'b0;
      end else begin
         pwm_cnt_next = pwm_cnt_reg + 1'b1;
         if (en_rise || wrap) begin
            duty_q_next = duty;
         end
         if (wrap) begin
            if (blink_cnt_reg == BLINK_LAST) begin
               blink_cnt_next   = '0;
               blink_phase_next = ~blink_phase_reg;
            end else begin
               blink_cnt_next = blink_cnt_reg + 1'b1;
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign blank_next[gi] = ~enable | ~pwm_on | blank_in[gi] |
                                 (blink_mask[gi] & blink_phase_reg);
         assign dp_next[gi]    = dp_in[gi] & ~blank_next[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt_reg     <= '0;
         duty_q_reg      <= '0;
         blink_cnt_reg   <= '0;
         blink_phase_reg <= 1'b0;
         enable_d_reg    <= 1'b0;
         Blank           <= '1;
         DP              <= '0;
         pwm_out         <= 1'b0;
         period_tick     <= 1'b0;
      end else begin
         pwm_cnt_reg     <= pwm_cnt_next;
         duty_q_reg      <= duty_q_next;
         blink_cnt_reg   <= blink_cnt_next;
         blink_phase_reg <= blink_phase_next;
         enable_d_reg    <= enable;
         Blank           <= blank_next;
         DP              <= dp_next;
         pwm_out         <= enable & pwm_on;
         period_tick     <= wrap;
      end
   end

endmodule

// File: tb/tb_display_pwm_blanker.sv
// Self-checking bench for display_pwm_blanker: directed steps plus random traffic,
// compared every cycle against a time-based reference model.
module tb_display_pwm_blanker;

   localparam int ND = 6;
   localparam int PW = 8;
   localparam int BP = 2;
   localparam int PERIOD = 1 << PW;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic [PW-1:0] duty;
   logic [ND-1:0] blank_in, dp_in, blink_mask;
   logic [ND-1:0] Blank, DP;
   logic          pwm_out, period_tick;

   display_pwm_blanker #(
      .NUM_DIGITS(ND), .PWM_WIDTH(PW), .BLINK_PERIODS(BP)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .duty(duty),
      .blank_in(blank_in), .dp_in(dp_in), .blink_mask(blink_mask),
      .Blank(Blank), .DP(DP), .pwm_out(pwm_out), .period_tick(period_tick)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   string tag;

   // Reference model: t = clk cycles since the display was (re)enabled.
   bit            running = 0;
   longint        t = 0;
   int            pduty = 0;
   logic [ND-1:0] exp_blank = '1, exp_dp = '0;
   logic          exp_pwm = 0, exp_tick = 0;

   task automatic model_step();
      int  cnt, ph;
      bit  on, b;
      if (!reset_n || !enable) begin
         running   = 0;
         exp_blank = '1;
         exp_dp    = '0;
         exp_pwm   = 0;
         exp_tick  = 0;
      end else begin
         if (!running) begin
            running = 1;
            t       = 0;
            pduty   = int'(duty);
         end
         cnt = int'(t % PERIOD);
         ph  = int'(((t / PERIOD) / BP) % 2);
         on  = (cnt < pduty);
         for (int i = 0; i < ND; i++) begin
            b            = !on || blank_in[i] || (blink_mask[i] && ph == 1);
            exp_blank[i] = b;
            exp_dp[i]    = dp_in[i] && !b;
         end
         exp_pwm  = on;
         exp_tick = (cnt == PERIOD - 1);
         t++;
         if (t % PERIOD == 0) pduty = int'(duty);
      end
   endtask

   task automatic chk();
      checks++;
      assert (Blank === exp_blank) else begin
         errors++; $error("FAIL %s Blank got %h exp %h", tag, Blank, exp_blank);
      end
      checks++;
      assert (DP === exp_dp) else begin
         errors++; $error("FAIL %s DP got %h exp %h", tag, DP, exp_dp);
      end
      checks++;
      assert (pwm_out === exp_pwm) else begin
         errors++; $error("FAIL %s pwm_out got %b exp %b", tag, pwm_out, exp_pwm);
      end
      checks++;
      assert (period_tick === exp_tick) else begin
         errors++; $error("FAIL %s period_tick got %b exp %b", tag, period_tick, exp_tick);
      end
   endtask

   // One clock: model consumes inputs mid-cycle, outputs checked 1 time unit after the edge.
   task automatic cyc();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      chk();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wait_cnt(input int target);
      int guard = 0;
      while (!(running && (t % PERIOD) == target) && guard < 2 * PERIOD) begin
         cyc();
         guard++;
      end
      checks++;
      assert (guard < 2 * PERIOD) else begin
         errors++; $error("FAIL %s wait_cnt timeout got %0d exp <%0d", tag, guard, 2 * PERIOD);
      end
   endtask

   task automatic count_dark(input int n, input int digit, output int dark);
      dark = 0;
      for (int i = 0; i < n; i++) begin
         cyc();
         if (Blank[digit] === 1'b0) dark++;
      end
   endtask

   task automatic chk_val(input string name, input int got, input int want);
      checks++;
      assert (got == want) else begin
         errors++; $error("FAIL %s %s got %0d exp %0d", tag, name, got, want);
      end
   endtask

   initial begin
      int n0, n1;
      reset_n = 0; enable = 0; duty = '0;
      blank_in = '0; dp_in = '0; blink_mask = '0;

      tag = "reset";
      run(4);
      reset_n = 1;
      run(300);
      $display("step 1 reset/idle: checks=%0d errors=%0d", checks, errors);

      tag = "duty64";
      dp_in = 6'h2A; duty = 8'd64; enable = 1;
      count_dark(512, 0, n0);
      chk_val("on_cycles_512", n0, 128);
      $display("step 2 duty=64: on=%0d checks=%0d errors=%0d", n0, checks, errors);

      tag = "duty_change";
      wait_cnt(100);
      duty = 8'd192;
      run(2 * PERIOD);
      $display("step 3 duty 64->192 mid-period: checks=%0d errors=%0d", checks, errors);

      tag = "duty0";
      duty = 8'd0;
      run(PERIOD);
      count_dark(PERIOD, 3, n0);
      chk_val("on_cycles_duty0", n0, 0);
      tag = "duty255";
      duty = 8'd255;
      run(PERIOD);
      count_dark(2 * PERIOD, 3, n0);
      chk_val("on_cycles_duty255", n0, 510);
      $display("step 4 duty extremes: checks=%0d errors=%0d", checks, errors);

      tag = "blink";
      enable = 0; dp_in = 6'h3F; blink_mask = 6'b000001;
      cyc();
      enable = 1;
      n0 = 0; n1 = 0;
      for (int i = 0; i < 4 * PERIOD; i++) begin
         cyc();
         if (Blank[0] === 1'b0) n0++;
         if (Blank[1] === 1'b0) n1++;
      end
      chk_val("digit0_on", n0, 510);
      chk_val("digit1_on", n1, 1020);
      $display("step 5 blink: d0=%0d d1=%0d checks=%0d errors=%0d", n0, n1, checks, errors);

      tag = "enable_drop";
      blink_mask = '0;
      wait_cnt(30);
      enable = 0;
      cyc();
      chk_val("blank_after_fall", int'(Blank), 63);
      run(9);
      enable = 1; duty = 8'd16;
      count_dark(PERIOD, 2, n0);
      chk_val("restart_on", n0, 16);
      tag = "async_reset";
      wait_cnt(50);
      #3;
      reset_n = 0;
      #1;
      chk_val("rst_blank", int'(Blank), 63);
      chk_val("rst_dp", int'(DP), 0);
      chk_val("rst_pwm", int'(pwm_out), 0);
      run(3);
      reset_n = 1; duty = 8'd40;
      run(2 * PERIOD);
      $display("step 6 enable drop/reset: checks=%0d errors=%0d", checks, errors);

      tag = "random";
      for (int i = 0; i < 4000; i++) begin
         blank_in   = ($urandom_range(0, 3) == 0) ? ND'($urandom) : '0;
         dp_in      = ND'($urandom);
         blink_mask = ($urandom_range(0, 1) == 0) ? ND'($urandom) : '0;
         if ($urandom_range(0, 99) == 0) duty = PW'($urandom);
         if ($urandom_range(0, 499) == 0) enable = ~enable;
         cyc();
      end
      $display("step 7 random: checks=%0d errors=%0d", checks, errors);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
